// File: rtl/router_pkg.sv
// Shared definitions for the mesh router: channel order, routing algorithms
// and the one-hot direction type used for routes and crossbar selects.
package router_pkg;

   localparam int LOCAL    = 0;
   localparam int NORTH    = 1;
   localparam int EAST     = 2;
   localparam int SOUTH    = 3;
   localparam int WEST     = 4;
   localparam int NUM_DIRS = 5;

   typedef enum logic [1:0] {
      ALG_XY         = 2'd0,
      ALG_YX         = 2'd1,
      ALG_WEST_FIRST = 2'd2
   } algorithm_e;

   typedef logic [NUM_DIRS-1:0] dir_t;

   function automatic dir_t dir_onehot(input int idx);
      dir_onehot      = '0;
      dir_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/route_allocator_rr_arbiter.sv
// Round-robin arbiter for one output channel. The scan starts at the
// registered pointer; the pointer moves past the winner on each grant.
// While the output is locked no grant is issued and the pointer holds.
module rr_arbiter #(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         lock,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic          found;
   int            win;
   int            idx;

   // Pick the first requester at or after the pointer, wrapping around.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so
      // no path leaves a value held and no latch is inferred.
      gnt   = '0;
      found = 1'b0;
      win   = 0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!found && !lock && req[idx]) begin
            gnt[idx] = 1'b1;
            win      = idx;
            found    = 1'b1;
         end
      end
   end

   // Advance the pointer to one past the winner whenever a grant is issued.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      if (rst)
         ptr_q <= '0;
      else if (found)
         ptr_q <= (win == N-1) ? '0 : PW'(win + 1);
   end

endmodule

// File: rtl/route_allocator.sv
// Route compute and wormhole output allocation for one mesh router.
// Each waiting head is routed combinationally, one round-robin arbiter per
// output picks a winner, and the winner keeps the output until its tail.
module route_allocator
   import router_pkg::*;
#(
   parameter int MAX_ROUTERS_X       = 4,
   parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
   parameter int MAX_ROUTERS_Y       = 4,
   parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
   parameter int ROUTER_X            = 0,
   parameter int ROUTER_Y            = 0,
   parameter int CHANNEL_NUMBER      = 5,
   parameter int ALGORITHM           = 0
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [CHANNEL_NUMBER-1:0]                     in_req,
   input  logic [CHANNEL_NUMBER*MAX_ROUTERS_X_WIDTH-1:0] in_target_x,
   input  logic [CHANNEL_NUMBER*MAX_ROUTERS_Y_WIDTH-1:0] in_target_y,
   input  logic [CHANNEL_NUMBER-1:0]                     in_fire,
   input  logic [CHANNEL_NUMBER-1:0]                     in_last,
   input  logic [CHANNEL_NUMBER-1:0]                     out_busy,
   output logic [CHANNEL_NUMBER-1:0]                     in_grant,
   output logic [CHANNEL_NUMBER*CHANNEL_NUMBER-1:0]      in_sel,
   output logic [CHANNEL_NUMBER-1:0]                     out_locked,
   output logic                                          route_err
);

   localparam int C  = CHANNEL_NUMBER;
   localparam int XW = MAX_ROUTERS_X_WIDTH;
   localparam int YW = MAX_ROUTERS_Y_WIDTH;

   if (CHANNEL_NUMBER != NUM_DIRS) begin : g_bad_channel_number
      $error("route_allocator requires CHANNEL_NUMBER == 5");
   end

   dir_t         sel_q   [C];
   dir_t         route   [C];
   dir_t         new_sel [C];
   logic [C-1:0] arb_req [C];
   logic [C-1:0] arb_gnt [C];
   logic [C-1:0] bad;
   logic [C-1:0] new_gnt;
   int           tx, ty, alt;
   logic         go_e, go_n, go_s;

   // Owned selects drive the crossbar; an output is locked while any input holds it.
   always_comb begin
      in_grant   = '0;
      in_sel     = '0;
      out_locked = '0;
      for (int i = 0; i < C; i++) begin
         in_grant[i]      = |sel_q[i];
         in_sel[i*C +: C] = sel_q[i];
         out_locked       = out_locked | sel_q[i];
      end
   end

   // Per-input route from the head target; out-of-range targets go local.
   always_comb begin
      tx   = 0;
      ty   = 0;
      alt  = NORTH;
      go_e = 1'b0;
      go_n = 1'b0;
      go_s = 1'b0;
      bad  = '0;
      for (int i = 0; i < C; i++) begin
         tx       = int'(in_target_x[i*XW +: XW]);
         ty       = int'(in_target_y[i*YW +: YW]);
         go_e     = tx > ROUTER_X;
         go_n     = ty < ROUTER_Y;
         go_s     = ty > ROUTER_Y;
         alt      = go_n ? NORTH : SOUTH;
         route[i] = dir_onehot(LOCAL);
         if (tx >= MAX_ROUTERS_X || ty >= MAX_ROUTERS_Y) begin
            bad[i] = 1'b1;
         end else if (ALGORITHM == int'(ALG_WEST_FIRST)) begin
            if (tx < ROUTER_X)
               route[i] = dir_onehot(WEST);
            else if (go_e && (go_n || go_s)) begin
               // Take the vertical hop only when it is free and east is not.
               if (!out_busy[alt] && !out_locked[alt] && (out_busy[EAST] || out_locked[EAST]))
                  route[i] = dir_onehot(alt);
               else
                  route[i] = dir_onehot(EAST);
            end
            else if (go_e) route[i] = dir_onehot(EAST);
            else if (go_n) route[i] = dir_onehot(NORTH);
            else if (go_s) route[i] = dir_onehot(SOUTH);
         end else if (ALGORITHM == int'(ALG_YX)) begin
            if      (go_n)          route[i] = dir_onehot(NORTH);
            else if (go_s)          route[i] = dir_onehot(SOUTH);
            else if (go_e)          route[i] = dir_onehot(EAST);
            else if (tx < ROUTER_X) route[i] = dir_onehot(WEST);
         end else begin
            if      (go_e)          route[i] = dir_onehot(EAST);
            else if (tx < ROUTER_X) route[i] = dir_onehot(WEST);
            else if (go_n)          route[i] = dir_onehot(NORTH);
            else if (go_s)          route[i] = dir_onehot(SOUTH);
         end
      end
   end

   // Only waiting, unowned inputs request, and each requests exactly one output.
   always_comb begin
      for (int o = 0; o < C; o++)
         for (int i = 0; i < C; i++)
            arb_req[o][i] = in_req[i] & ~in_grant[i] & route[i][o];
   end

   for (genvar o = 0; o < C; o++) begin : g_arb
      rr_arbiter #(.N(C)) u_arb (
         .clk  (clk),
         .rst  (rst),
         .req  (arb_req[o]),
         .lock (out_locked[o]),
         .gnt  (arb_gnt[o])
      );
   end

   // Transpose arbiter grants into a one-hot select per input.
   always_comb begin
      new_gnt = '0;
      for (int i = 0; i < C; i++) begin
         for (int o = 0; o < C; o++)
            new_sel[i][o] = arb_gnt[o][i];
         new_gnt[i] = |new_sel[i];
      end
   end

   // Capture the route at grant time, hold it until the tail fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < C; i++) sel_q[i] <= '0;
         route_err <= 1'b0;
      end else begin
         for (int i = 0; i < C; i++) begin
            if (in_grant[i] && in_fire[i] && in_last[i])
               sel_q[i] <= '0;
            else if (new_gnt[i])
               sel_q[i] <= new_sel[i];
         end
         route_err <= |(new_gnt & bad);
      end
   end

endmodule

// File: doc/route_allocator.md
Name: route_allocator

Overview:
Registered route-compute and output-allocation stage for one mesh router. Each input channel presents the destination of its head flit. The block selects an output channel using a parameter-selected algorithm: XY, YX or west-first adaptive. A per-output round-robin arbiter then grants the output and holds it (wormhole lock) until that input's tail flit transfers. It sits between the input buffers and the crossbar, driving the crossbar select lines.

Parameters:
MAX_ROUTERS_X, 4, mesh width in routers
MAX_ROUTERS_X_WIDTH, $clog2(MAX_ROUTERS_X), target_x width
MAX_ROUTERS_Y, 4, mesh height in routers
MAX_ROUTERS_Y_WIDTH, $clog2(MAX_ROUTERS_Y), target_y width
ROUTER_X, 0, this router's X coordinate
ROUTER_Y, 0, this router's Y coordinate
CHANNEL_NUMBER, 5, port count; fixed order 0=local, 1=north (y-), 2=east (x+), 3=south (y+), 4=west (x-); values other than 5 rejected at elaboration
ALGORITHM, 0, 0=XY, 1=YX, 2=west-first adaptive

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_req  in  CHANNEL_NUMBER  input i has a head flit waiting for allocation
in_target_x  in  CHANNEL_NUMBER*MAX_ROUTERS_X_WIDTH  head destination X, packed, slice i belongs to input i
in_target_y  in  CHANNEL_NUMBER*MAX_ROUTERS_Y_WIDTH  head destination Y, packed
in_fire  in  CHANNEL_NUMBER  a flit of input i crossed the crossbar this cycle
in_last  in  CHANNEL_NUMBER  qualifies in_fire: the flit is a tail
out_busy  in  CHANNEL_NUMBER  downstream congestion hint; used only by ALGORITHM=2
in_grant  out  CHANNEL_NUMBER  input i owns an output
in_sel  out  CHANNEL_NUMBER*CHANNEL_NUMBER  one-hot output select per input; zero when in_grant[i]=0
out_locked  out  CHANNEL_NUMBER  output o is owned
route_err  out  1  one-cycle pulse when a granted head had an out-of-range target

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high.
- Reset values: all outputs 0, all locks cleared, all round-robin pointers 0. Reset mid-packet drops every lock; outputs are 0 on the cycle after the rst edge.
- Route compute (combinational, per input, from the head target):
  - XY: x>ROUTER_X -> east; x<ROUTER_X -> west; else y<ROUTER_Y -> north; y>ROUTER_Y -> south; else local.
  - YX: same rules with the Y decision first.
  - West-first (ALGORITHM=2):
    - x<ROUTER_X -> west, unconditionally.
    - Otherwise the candidates are east (if x>), north (if y<) and south (if y>).
    - With two candidates, choose the one with out_busy=0 and out_locked=0.
    - If both or neither qualify, choose east.
    - With one candidate, choose it.
- Out-of-range targets: target_x>=MAX_ROUTERS_X or target_y>=MAX_ROUTERS_Y routes to local. route_err pulses in the grant cycle.
- Arbitration, evaluated each cycle for every output o with out_locked[o]=0:
  - Requesters are inputs with in_req=1, in_grant=0 and a route equal to o.
  - The winner is the first requester scanning upward from ptr[o], wrapping modulo CHANNEL_NUMBER.
  - On a grant, ptr[o] becomes winner+1 (mod CHANNEL_NUMBER).
  - An input requests only one output per cycle, so no input is ever double-granted.
- Latency: in_req sampled high at edge t -> in_grant, in_sel and out_locked are high after edge t.
- The route is captured at grant time. While granted, changes to the head target or to out_busy are ignored.
- Release: in_fire[i]&in_last[i] while granted clears in_grant[i], in_sel[i] and the lock at the next edge. The freed output cannot be re-granted on that same edge; the earliest new grant is one edge later.
- Single-flit packet: a tail fire in the first granted cycle releases normally.
- Ignored inputs: in_fire on an ungranted input is ignored. in_req dropping before grant has no effect. in_req while granted is ignored.
- Head-of-line: an input that loses arbitration keeps requesting; no starvation, because the pointer rotates.

Decomposition:
- Package router_pkg holds:
  - channel index localparams (LOCAL, NORTH, EAST, SOUTH, WEST)
  - algorithm enum (ALG_XY, ALG_YX, ALG_WEST_FIRST)
  - a one-hot direction typedef
- One sub-module, rr_arbiter: parametrised request width, a registered pointer and a lock input. Instantiate one per output.

Test Plan:
1. Config ROUTER=(1,1), 4x4 mesh, ALGORITHM=0. in_req[0]=1, target (3,0) -> one edge later: in_grant[0]=1, in_sel[0]=5'b00100, out_locked[2]=1.
2. Same stimulus with ALGORITHM=1 -> in_sel[0]=5'b00010 (north), out_locked[1]=1.
3. Inputs 1 and 3 both target (3,1) in the same cycle, pointer at 0:
   - Input 1 is granted east.
   - Tail fire on input 1 at edge t -> out_locked[2]=0 after t.
   - in_grant[3]=1 after t+1.
4. ALGORITHM=2, target (3,3):
   - out_busy[2]=1 -> in_sel=5'b01000 (south).
   - Target (0,3) with out_busy[4]=1 -> west 5'b10000 regardless.
5. rst pulsed while inputs 0 and 2 hold locks -> all outputs 0 next cycle; a re-request is granted one edge after rst deasserts.
6. Config MAX_ROUTERS_X=3, target_x=3 -> in_sel=5'b00001 (local) and a one-cycle route_err=1.
